reg_array_sb: RTL and testbench

- Parametrised general-purpose register file for the RISC-V core with an integrated pending-write scoreboard.
- Two read ports and one write port, sized by parameters. Register 0 can be hardwired to zero.
- Optional write-to-read bypass and optional registered read outputs.
- Sits between decode (read and issue) and writeback (write). Provides read operands and per-operand busy flags for hazard stalls.

---
 rtl/reg_array_sb.sv | 78 +++++++
 tb/tb_reg_array_sb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/reg_array_sb.sv
// reg_array_sb: 2R/1W register file with a 1-bit pending-write scoreboard,
// optional write bypass and optional registered read outputs.
module reg_array_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic                 clk_Regs,
  input  logic                 rst_n_Regs,
  input  logic                 Reg_Write,
  input  logic [ADDR_W-1:0]    W_Addr,
  input  logic [DATA_W-1:0]    W_Data,
  input  logic [ADDR_W-1:0]    R_Addr_A,
  input  logic [ADDR_W-1:0]    R_Addr_B,
  input  logic                 Rd_En,
  input  logic                 Issue_Valid,
  input  logic [ADDR_W-1:0]    Issue_Addr,
  output logic [DATA_W-1:0]    R_Data_A,
  output logic [DATA_W-1:0]    R_Data_B,
  output logic                 Busy_A,
  output logic                 Busy_B,
  output logic [2**ADDR_W-1:0] Pending
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic              wr_ok, iss_ok, zero_a, zero_b, byp_a, byp_b;
  logic [DATA_W-1:0] val_a, val_b;
  assign wr_ok  = Reg_Write && !(ZERO_REG && W_Addr == '0);
  assign iss_ok = Issue_Valid && !(ZERO_REG && Issue_Addr == '0);
  // Set is applied after clear so a same-cycle issue keeps the newer producer pending.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) pending_d[W_Addr] = 1'b0;
    if (iss_ok) pending_d[Issue_Addr] = 1'b1;
  end
  always_ff @(posedge clk_Regs or negedge rst_n_Regs) begin
    if (!rst_n_Regs) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      if (wr_ok) regs_q[W_Addr] <= W_Data;
      pending_q <= pending_d;
    end
  end
  assign zero_a = ZERO_REG && R_Addr_A == '0;
  assign zero_b = ZERO_REG && R_Addr_B == '0;
  assign byp_a  = BYPASS && Reg_Write && W_Addr == R_Addr_A;
  assign byp_b  = BYPASS && Reg_Write && W_Addr == R_Addr_B;
  assign val_a  = zero_a ? '0 : byp_a ? W_Data : regs_q[R_Addr_A];
  assign val_b  = zero_b ? '0 : byp_b ? W_Data : regs_q[R_Addr_B];
  assign Busy_A = !zero_a && !byp_a && pending_q[R_Addr_A];
  assign Busy_B = !zero_b && !byp_b && pending_q[R_Addr_B];
  assign Pending = pending_q;
  generate
    if (READ_REG) begin : g_rreg
      logic [DATA_W-1:0] rd_a_q, rd_b_q;
      always_ff @(posedge clk_Regs or negedge rst_n_Regs) begin
        if (!rst_n_Regs) begin
          rd_a_q <= '0;
          rd_b_q <= '0;
        end else if (Rd_En) begin
          rd_a_q <= val_a;
          rd_b_q <= val_b;
        end
      end
      assign R_Data_A = rd_a_q;
      assign R_Data_B = rd_b_q;
    end else begin : g_rcomb
      logic unused_rd_en;
      assign unused_rd_en = Rd_En;
      assign R_Data_A = val_a;
      assign R_Data_B = val_b;
    end
  endgenerate
endmodule

// File: tb/tb_reg_array_sb.sv
// tb_reg_array_sb: directed checks of a bypassing combinational instance and a
// non-bypassing registered-read instance driven by the same stimulus.
module tb_reg_array_sb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr = 1'b0, rd_en = 1'b0, iss = 1'b0;
  logic [4:0]  wa = '0, ra = '0, rb = '0, ia = '0;
  logic [31:0] wd = '0;
  logic [31:0] da0, db0, da1, db1, pend0, pend1;
  logic        ba0, bb0, ba1, bb1;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  reg_array_sb u0 (
    .clk_Regs(clk), .rst_n_Regs(rst_n), .Reg_Write(wr), .W_Addr(wa), .W_Data(wd),
    .R_Addr_A(ra), .R_Addr_B(rb), .Rd_En(rd_en), .Issue_Valid(iss), .Issue_Addr(ia),
    .R_Data_A(da0), .R_Data_B(db0), .Busy_A(ba0), .Busy_B(bb0), .Pending(pend0)
  );
  reg_array_sb #(.BYPASS(1'b0), .READ_REG(1'b1)) u1 (
    .clk_Regs(clk), .rst_n_Regs(rst_n), .Reg_Write(wr), .W_Addr(wa), .W_Data(wd),
    .R_Addr_A(ra), .R_Addr_B(rb), .Rd_En(rd_en), .Issue_Valid(iss), .Issue_Addr(ia),
    .R_Data_A(da1), .R_Data_B(db1), .Busy_A(ba1), .Busy_B(bb1), .Pending(pend1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr = 1'b1; wa = a; wd = d;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_rda0", da0, 32'h0);
    chk("rst_pend0", pend0, 32'h0);
    chk("rst_rda1", da1, 32'h0);
    #10 rst_n = 1'b1;
    // x0 ignores writes and overrides bypass
    wr = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra = 5'd0;
    #1 chk("x0_byp", da0, 32'h0);
    tick(); wr = 1'b0;
    #1 chk("x0_rd", da0, 32'h0);
    chk("x0_busy", {31'b0, ba0}, 32'h0);
    chk("x0_pend", pend0, 32'h0);
    write(5'd5, 32'h12345678);
    write(5'd31, 32'hFFFFFFFF);
    ra = 5'd5; rb = 5'd31; rd_en = 1'b1;
    #1 chk("rd_x5", da0, 32'h12345678);
    chk("rd_x31", db0, 32'hFFFFFFFF);
    tick();
    chk("rreg_x5", da1, 32'h12345678);
    chk("rreg_x31", db1, 32'hFFFFFFFF);
    // bypass vs. old array contents on a same-cycle write
    write(5'd7, 32'h11111111);
    wr = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = 5'd7;
    #1 chk("byp_x7", da0, 32'hA5A5A5A5);
    tick(); wr = 1'b0;
    #1 chk("nobyp_x7", da1, 32'h11111111);
    tick();
    chk("after_x7_r", da1, 32'hA5A5A5A5);
    chk("after_x7_c", da0, 32'hA5A5A5A5);
    rd_en = 1'b0;
    // scoreboard on x3
    iss = 1'b1; ia = 5'd3; ra = 5'd3; rb = 5'd3;
    #1 chk("iss_nobusy", {31'b0, ba0}, 32'h0);
    tick(); iss = 1'b0;
    #1 chk("iss_pend", pend0, 32'h8);
    chk("iss_busy_a", {31'b0, ba0}, 32'h1);
    chk("iss_busy_b1", {31'b0, bb1}, 32'h1);
    wr = 1'b1; wa = 5'd3; wd = 32'h33;
    #1 chk("wr_busy_byp", {31'b0, ba0}, 32'h0);
    chk("wr_busy_nobyp", {31'b0, ba1}, 32'h1);
    tick(); wr = 1'b0;
    #1 chk("wr_clr0", pend0, 32'h0);
    chk("wr_clr1", pend1, 32'h0);
    wr = 1'b1; wa = 5'd3; wd = 32'h34; iss = 1'b1; ia = 5'd3;
    tick(); wr = 1'b0; iss = 1'b0;
    #1 chk("set_wins", pend0, 32'h8);
    chk("set_wins_data", da0, 32'h34);
    iss = 1'b1; ia = 5'd0;
    tick();
    ia = 5'd3;
    tick(); iss = 1'b0;
    #1 chk("iss_x0_rep", pend0, 32'h8);
    // registered read hold
    write(5'd9, 32'h55);
    rd_en = 1'b1; ra = 5'd9;
    tick(); rd_en = 1'b0; ra = 5'd0;
    #1 chk("rreg_x9", da1, 32'h55);
    chk("comb_x0", da0, 32'h0);
    tick();
    chk("rreg_hold", da1, 32'h55);
    // asynchronous reset between edges
    write(5'd4, 32'h44);
    iss = 1'b1; ia = 5'd6;
    tick(); iss = 1'b0;
    #1 chk("pre_rst_pend", pend0, 32'h48);
    ra = 5'd4; rb = 5'd6;
    #1 chk("pre_rst_x4", da0, 32'h44);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_pend", pend0, 32'h0);
    chk("mid_rst_rreg", da1, 32'h0);
    chk("mid_rst_x4", da0, 32'h0);
    chk("mid_rst_busy", {31'b0, bb0}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_x4", da0, 32'h0);
    chk("post_rst_pend1", pend1, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
